// File: rtl/hwpe_cfg_initiator_pkg.sv
// Shared types for the HWPE configuration-bus initiator: the queued command layout and defaults.
package hwpe_cfg_initiator_pkg;

    localparam int unsigned AW               = 32;
    localparam int unsigned DW               = 32;
    localparam int unsigned ID_WIDTH_DEFAULT = 8;

    typedef struct packed {
        logic            wen;
        logic [AW-1:0]   add;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
    } hwpe_cfg_cmd_t;

endpackage

// File: rtl/hwpe_cfg_cmd_fifo.sv
// Synchronous command FIFO for the HWPE config initiator; head entry is presented on data_o.
module hwpe_cfg_cmd_fifo
    import hwpe_cfg_initiator_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  hwpe_cfg_cmd_t data_i,
    input  logic          pop_i,
    output hwpe_cfg_cmd_t data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(Depth);

    hwpe_cfg_cmd_t   mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   cnt_q;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/hwpe_cfg_initiator.sv
// Initiator side of the HWPE peripheral config bus: queues commands, issues req/gnt, collects
// in-order r_valid responses. Define HWPE_CFG_INITIATOR_ID_CHECK_EN to flag response-id mismatches.
module hwpe_cfg_initiator
    import hwpe_cfg_initiator_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = ID_WIDTH_DEFAULT,
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_OUTST  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_wen_i,
    input  logic [AW-1:0]       cmd_add_i,
    input  logic [DW-1:0]       cmd_data_i,
    input  logic [DW/8-1:0]     cmd_be_i,
    output logic                periph_req_o,
    output logic [AW-1:0]       periph_add_o,
    output logic                periph_wen_o,
    output logic [DW/8-1:0]     periph_be_o,
    output logic [DW-1:0]       periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_gnt_i,
    input  logic                periph_r_valid_i,
    input  logic [DW-1:0]       periph_r_data_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,
    output logic                rsp_valid_o,
    output logic [DW-1:0]       rsp_data_o,
    output logic [ID_WIDTH-1:0] rsp_id_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] MaxOutst = OW'(MAX_OUTST);

    hwpe_cfg_cmd_t        cmd_in, head;
    logic                 fifo_full, fifo_empty;
    logic                 push, grant, rsp_hit, rsp_err, clear_ok, id_err;
    logic                 ready_q;
    logic [OW-1:0]        outst_q, outst_d, wen_idx;
    logic [MAX_OUTST-1:0] wen_q, wen_d;
    logic [ID_WIDTH-1:0]  issue_id_q;
    logic                 rsp_valid_q, err_q;
    logic [DW-1:0]        rsp_data_q;
    logic [ID_WIDTH-1:0]  rsp_id_q;

    assign cmd_in = '{wen: cmd_wen_i, add: cmd_add_i, data: cmd_data_i, be: cmd_be_i};

    // ready_q keeps cmd_ready_o low throughout reset and for its first edge.
    assign cmd_ready_o = ready_q & ~fifo_full;
    assign push        = cmd_valid_i & cmd_ready_o;

    hwpe_cfg_cmd_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (cmd_in),
        .pop_i   (grant),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign periph_req_o  = ~fifo_empty & ((outst_q < MaxOutst) | periph_r_valid_i);
    assign periph_add_o  = head.add;
    assign periph_wen_o  = head.wen;
    assign periph_be_o   = head.be;
    assign periph_data_o = head.data;
    assign periph_id_o   = issue_id_q;

    assign grant    = periph_req_o & periph_gnt_i;
    assign rsp_hit  = periph_r_valid_i & (outst_q != '0);
    assign rsp_err  = periph_r_valid_i & (outst_q == '0);
    assign busy_o   = ~fifo_empty | (outst_q != '0);
    assign clear_ok = clear_i & ~busy_o;

    // wen_q[0] is the oldest outstanding transaction; a response retires it first.
    always_comb begin
        outst_d = outst_q;
        wen_d   = wen_q;
        wen_idx = outst_q;
        if (rsp_hit) begin
            wen_d   = wen_q >> 1;
            wen_idx = outst_q - OW'(1);
            outst_d = outst_q - OW'(1);
        end
        if (grant) begin
            outst_d = outst_d + OW'(1);
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                if (OW'(i) == wen_idx) begin
                    wen_d[i] = head.wen;
                end
            end
        end
    end

`ifdef HWPE_CFG_INITIATOR_ID_CHECK_EN
    logic [ID_WIDTH-1:0] exp_id_q;

    assign id_err = rsp_hit & (periph_r_id_i != exp_id_q);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_ok) begin
            exp_id_q <= '0;
        end else if (rsp_hit) begin
            exp_id_q <= exp_id_q + ID_WIDTH'(1);
        end
    end
`else
    assign id_err = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q     <= 1'b0;
            outst_q     <= '0;
            wen_q       <= '0;
            issue_id_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            outst_q <= outst_d;
            wen_q   <= wen_d;
            if (clear_ok) begin
                issue_id_q <= '0;
            end else if (grant) begin
                issue_id_q <= issue_id_q + ID_WIDTH'(1);
            end
            rsp_valid_q <= rsp_hit & wen_q[0];
            if (rsp_hit & wen_q[0]) begin
                rsp_data_q <= periph_r_data_i;
                rsp_id_q   <= periph_r_id_i;
            end
            if (clear_ok) begin
                err_q <= 1'b0;
            end else if (rsp_err | id_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_hwpe_cfg_initiator.sv
// Directed bench for hwpe_cfg_initiator with a read-response scoreboard (ID_WIDTH=2 for id wrap).
module tb_hwpe_cfg_initiator;

    localparam int unsigned IDW = 2;

    logic           clk_i = 1'b0;
    logic           rst_i, clear_i, cmd_valid_i, cmd_ready_o, cmd_wen_i;
    logic [31:0]    cmd_add_i, cmd_data_i;
    logic [3:0]     cmd_be_i;
    logic           periph_req_o, periph_wen_o;
    logic [31:0]    periph_add_o, periph_data_o;
    logic [3:0]     periph_be_o;
    logic [IDW-1:0] periph_id_o;
    logic           periph_gnt_i, periph_r_valid_i;
    logic [31:0]    periph_r_data_i;
    logic [IDW-1:0] periph_r_id_i;
    logic           rsp_valid_o, busy_o, err_o;
    logic [31:0]    rsp_data_o;
    logic [IDW-1:0] rsp_id_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0]    data;
        logic [IDW-1:0] id;
    } rsp_t;
    rsp_t sb_q[$];

`ifdef HWPE_CFG_INITIATOR_ID_CHECK_EN
    localparam logic ID_ERR_EXP = 1'b1;
`else
    localparam logic ID_ERR_EXP = 1'b0;
`endif

    hwpe_cfg_initiator #(
        .ID_WIDTH   (IDW),
        .AW         (32),
        .DW         (32),
        .FIFO_DEPTH (4),
        .MAX_OUTST  (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .clear_i          (clear_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .cmd_wen_i        (cmd_wen_i),
        .cmd_add_i        (cmd_add_i),
        .cmd_data_i       (cmd_data_i),
        .cmd_be_i         (cmd_be_i),
        .periph_req_o     (periph_req_o),
        .periph_add_o     (periph_add_o),
        .periph_wen_o     (periph_wen_o),
        .periph_be_o      (periph_be_o),
        .periph_data_o    (periph_data_o),
        .periph_id_o      (periph_id_o),
        .periph_gnt_i     (periph_gnt_i),
        .periph_r_valid_i (periph_r_valid_i),
        .periph_r_data_i  (periph_r_data_i),
        .periph_r_id_i    (periph_r_id_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_data_o       (rsp_data_o),
        .rsp_id_o         (rsp_id_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic wen, input logic [31:0] add,
                           input logic [31:0] data, input logic [3:0] be,
                           input logic [IDW-1:0] id);
        check({tag, "_req"}, 32'(periph_req_o), 32'(1));
        check({tag, "_add"}, periph_add_o, add);
        check({tag, "_wen"}, 32'(periph_wen_o), 32'(wen));
        check({tag, "_data"}, periph_data_o, data);
        check({tag, "_be"}, 32'(periph_be_o), 32'(be));
        check({tag, "_id"}, 32'(periph_id_o), 32'(id));
    endtask

    task automatic push_cmd(input logic wen, input logic [31:0] add, input logic [31:0] data,
                            input logic [3:0] be);
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_wen_i   = wen;
        cmd_add_i   = add;
        cmd_data_i  = data;
        cmd_be_i    = be;
        #1 check("cmd_ready", 32'(cmd_ready_o), 32'(1));
        @(posedge clk_i);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic grant_once(input string tag, input logic wen, input logic [31:0] add,
                              input logic [31:0] data, input logic [3:0] be,
                              input logic [IDW-1:0] id);
        @(negedge clk_i);
        periph_gnt_i = 1'b1;
        #1 chk_req(tag, wen, add, data, be, id);
        @(posedge clk_i);
        #1 periph_gnt_i = 1'b0;
    endtask

    task automatic respond(input logic is_read, input logic [31:0] data,
                           input logic [IDW-1:0] id);
        @(negedge clk_i);
        periph_r_valid_i = 1'b1;
        periph_r_data_i  = data;
        periph_r_id_i    = id;
        if (is_read) sb_q.push_back('{data: data, id: id});
        @(posedge clk_i);
        #1 periph_r_valid_i = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk_i);
        clear_i = 1'b1;
        @(posedge clk_i);
        #1 clear_i = 1'b0;
    endtask

    // Every rsp_valid pulse must match the oldest read response driven so far.
    always @(negedge clk_i) begin
        if (rsp_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid_o), 32'(0));
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_data", rsp_data_o, e.data);
                check("rsp_id", 32'(rsp_id_o), 32'(e.id));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; cmd_valid_i = 1'b0; cmd_wen_i = 1'b0;
        cmd_add_i = '0; cmd_data_i = '0; cmd_be_i = '0;
        periph_gnt_i = 1'b0; periph_r_valid_i = 1'b0; periph_r_data_i = '0; periph_r_id_i = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        check("rst_req", 32'(periph_req_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_err", 32'(err_o), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'(0));
        check("rst_ready", 32'(cmd_ready_o), 32'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("rst_ready_after", 32'(cmd_ready_o), 32'(1));
        check("rst_id", 32'(periph_id_o), 32'(0));

        // Single write, immediate grant, response next cycle
        push_cmd(1'b0, 32'h20, 32'hDEADBEEF, 4'hF);
        grant_once("t1", 1'b0, 32'h20, 32'hDEADBEEF, 4'hF, 2'd0);
        @(negedge clk_i);
        periph_r_valid_i = 1'b1; periph_r_id_i = 2'd0; periph_r_data_i = '0;
        #1;
        check("t1_req_once", 32'(periph_req_o), 32'(0));
        check("t1_busy_outst", 32'(busy_o), 32'(1));
        @(posedge clk_i);
        #1 periph_r_valid_i = 1'b0;
        @(negedge clk_i);
        #1 check("t1_busy_done", 32'(busy_o), 32'(0));

        // Read with grant delayed 3 cycles; ids cleared first
        do_clear();
        push_cmd(1'b1, 32'h0C, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            #1 chk_req("t2_wait", 1'b1, 32'h0C, 32'h0, 4'hF, 2'd0);
        end
        grant_once("t2_gnt", 1'b1, 32'h0C, 32'h0, 4'hF, 2'd0);
        respond(1'b1, 32'h1234, 2'd0);
        @(negedge clk_i);
        #1 check("t2_req_idle", 32'(periph_req_o), 32'(0));

        // Four writes queued, MAX_OUTST=2 throttles grants; ids 1,2,3,0
        for (int k = 0; k < 4; k++) begin
            push_cmd(1'b0, 32'(32'h40 + 4 * k), 32'(32'h1000 + k), 4'h3);
        end
        @(negedge clk_i);
        periph_gnt_i = 1'b1;
        #1;
        check("t3_full_ready", 32'(cmd_ready_o), 32'(0));
        chk_req("t3_g0", 1'b0, 32'h40, 32'h1000, 4'h3, 2'd1);
        @(negedge clk_i);
        #1;
        chk_req("t3_g1", 1'b0, 32'h44, 32'h1001, 4'h3, 2'd2);
        check("t3_ready_after_pop", 32'(cmd_ready_o), 32'(1));
        @(negedge clk_i);
        #1 check("t3_stall0", 32'(periph_req_o), 32'(0));
        @(negedge clk_i);
        #1 check("t3_stall1", 32'(periph_req_o), 32'(0));
        @(negedge clk_i);
        periph_r_valid_i = 1'b1; periph_r_id_i = 2'd1;
        #1 chk_req("t3_g2", 1'b0, 32'h48, 32'h1002, 4'h3, 2'd3);
        @(negedge clk_i);
        periph_r_valid_i = 1'b0;
        #1 check("t3_stall2", 32'(periph_req_o), 32'(0));
        @(negedge clk_i);
        periph_r_valid_i = 1'b1; periph_r_id_i = 2'd2;
        #1 chk_req("t3_g3", 1'b0, 32'h4C, 32'h1003, 4'h3, 2'd0);
        @(negedge clk_i);
        periph_r_valid_i = 1'b0; periph_gnt_i = 1'b0;
        #1;
        check("t3_drained", 32'(periph_req_o), 32'(0));
        check("t3_busy", 32'(busy_o), 32'(1));
        respond(1'b0, 32'h0, 2'd3);
        respond(1'b0, 32'h0, 2'd0);
        @(negedge clk_i);
        #1 check("t3_idle", 32'(busy_o), 32'(0));

        // Five reads with 2-bit ids: 0,1,2,3,0
        do_clear();
        for (int k = 0; k < 5; k++) begin
            push_cmd(1'b1, 32'(32'h100 + 4 * k), 32'h0, 4'hF);
            grant_once("t4", 1'b1, 32'(32'h100 + 4 * k), 32'h0, 4'hF, IDW'(k));
            respond(1'b1, 32'(32'hA000 + k), IDW'(k));
        end
        @(negedge clk_i);
        #1 check("t4_err", 32'(err_o), 32'(0));

        // Response id mismatch (expected 1, returned 3); response still forwarded
        push_cmd(1'b1, 32'h200, 32'h0, 4'hF);
        grant_once("t5", 1'b1, 32'h200, 32'h0, 4'hF, 2'd1);
        respond(1'b1, 32'h55, 2'd3);
        @(negedge clk_i);
        #1 check("t5_err_set", 32'(err_o), 32'(ID_ERR_EXP));
        @(negedge clk_i);
        #1 check("t5_err_sticky", 32'(err_o), 32'(ID_ERR_EXP));
        do_clear();
        @(negedge clk_i);
        #1 check("t5_err_clear", 32'(err_o), 32'(0));

        // r_valid with nothing outstanding
        respond(1'b0, 32'h0, 2'd0);
        @(negedge clk_i);
        #1;
        check("t5b_err_proto", 32'(err_o), 32'(1));
        check("t5b_busy", 32'(busy_o), 32'(0));
        do_clear();
        @(negedge clk_i);
        #1 check("t5b_err_clear", 32'(err_o), 32'(0));

        // Reset while a request waits for grant
        push_cmd(1'b0, 32'h300, 32'hAA, 4'hF);
        grant_once("t6_first", 1'b0, 32'h300, 32'hAA, 4'hF, 2'd0);
        push_cmd(1'b0, 32'h304, 32'hBB, 4'hF);
        @(negedge clk_i);
        #1 chk_req("t6_pending", 1'b0, 32'h304, 32'hBB, 4'hF, 2'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("t6_req_drop", 32'(periph_req_o), 32'(0));
        check("t6_busy", 32'(busy_o), 32'(0));
        check("t6_ready", 32'(cmd_ready_o), 32'(0));
        rst_i = 1'b0;
        @(negedge clk_i);
        #1 check("t6_ready_back", 32'(cmd_ready_o), 32'(1));
        push_cmd(1'b1, 32'h308, 32'h0, 4'hF);
        grant_once("t6_after", 1'b1, 32'h308, 32'h0, 4'hF, 2'd0);
        respond(1'b1, 32'hCAFE, 2'd0);
        @(negedge clk_i);
        #1 check("t6_err", 32'(err_o), 32'(0));

        repeat (3) @(negedge clk_i);
        check("sb_empty", 32'(sb_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
